// File: rtl/branch_ctrl.sv
// ID-stage branch resolution controller: load/ALU hazard stalls, redirect and flush,
// plus saturating branch statistics counters.
module branch_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_branch,
  input  logic [2:0]  id_comp_op,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic [4:0]  mem_rd,
  input  logic        mem_regwrite,
  input  logic        mem_memread,
  input  logic        comp_true,
  input  logic        pipe_flush,
  input  logic        stats_clr,
  output logic [2:0]  comp_op,
  output logic        stall,
  output logic        pc_sel,
  output logic        flush_ifid,
  output logic [15:0] branch_cnt,
  output logic [15:0] taken_cnt,
  output logic [15:0] stall_cnt
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {IDLE, WAIT, RESOLVE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_cnt;
  logic [1:0]       w_cnt_nxt;
  logic             w_resolve;
  logic             w_rt_used;
  logic             w_rs_live;
  logic             w_rt_live;
  logic             w_ex_hit;
  logic             w_mem_load_hit;
  logic [1:0]       w_need;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_taken_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  assign comp_op = id_comp_op;

  // Operand usage and hazard detection; register 0 never creates a dependency.
  assign w_rt_used      = (id_comp_op == 3'd0) || (id_comp_op == 3'd1);
  assign w_rs_live      = (id_rs != REG_W'(0));
  assign w_rt_live      = w_rt_used && (id_rt != REG_W'(0));
  assign w_ex_hit       = ex_regwrite &&
                          ((w_rs_live && (id_rs == ex_rd)) || (w_rt_live && (id_rt == ex_rd)));
  assign w_mem_load_hit = mem_regwrite && mem_memread &&
                          ((w_rs_live && (id_rs == mem_rd)) || (w_rt_live && (id_rt == mem_rd)));

  always_comb begin
    w_need = 2'd0;
    if (w_ex_hit && ex_memread) w_need = 2'd2;
    else if (w_ex_hit)          w_need = 2'd1;
    else if (w_mem_load_hit)    w_need = 2'd1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and control outputs; a pipe flush overrides any branch in progress.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    stall       = 1'b0;
    pc_sel      = 1'b0;
    flush_ifid  = 1'b0;
    w_resolve   = 1'b0;
    if (pipe_flush) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = 2'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (id_branch) begin
            if (w_need == 2'd0) begin
              w_resolve  = 1'b1;
              pc_sel     = comp_true;
              flush_ifid = comp_true;
            end else begin
              stall       = 1'b1;
              w_cnt_nxt   = 2'(w_need - 2'd1);
              w_state_nxt = (w_need == 2'd2) ? WAIT : RESOLVE;
            end
          end
        end
        WAIT: begin
          stall     = 1'b1;
          w_cnt_nxt = 2'(r_cnt - 2'd1);
          if (r_cnt <= 2'd1) begin
            w_cnt_nxt   = 2'd0;
            w_state_nxt = RESOLVE;
          end
        end
        RESOLVE: begin
          w_resolve   = 1'b1;
          pc_sel      = comp_true;
          flush_ifid  = comp_true;
          w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 2'd0;
        end
      endcase
    end
  end

  // Saturating statistics; clear wins over any increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_cnt <= '0;
      r_taken_cnt  <= '0;
      r_stall_cnt  <= '0;
    end else if (stats_clr) begin
      r_branch_cnt <= '0;
      r_taken_cnt  <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (w_resolve && (r_branch_cnt != '1))
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      if (w_resolve && comp_true && (r_taken_cnt != '1))
        r_taken_cnt <= r_taken_cnt + CNT_W'(1);
      if (stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign branch_cnt = r_branch_cnt;
  assign taken_cnt  = r_taken_cnt;
  assign stall_cnt  = r_stall_cnt;

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have these ports, in this order (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, reset; asynchronous, active-low.
- id_branch, in, 1, ID-stage instruction is a conditional branch.
- id_comp_op, in, 3, compare op: 0 beq, 1 bne, 2 blez, 3 bgtz, 4 bltz.
- id_rs, in, 5, ID source register A.
- id_rt, in, 5, ID source register B.
- ex_rd, in, 5, EX destination register.
- ex_regwrite, in, 1, EX writes a register.
- ex_memread, in, 1, EX is a load.
- mem_rd, in, 5, MEM destination register.
- mem_regwrite, in, 1, MEM writes a register.
- mem_memread, in, 1, MEM is a load.
- comp_true, in, 1, result from the combinational comparer.
- pipe_flush, in, 1, higher-priority flush from a later stage.
- stats_clr, in, 1, synchronous clear of the statistics counters.
- comp_op, out, 3, drives the comparer compOp.
- stall, out, 1, hold PC and IF/ID, bubble into EX.
- pc_sel, out, 1, 1 selects the branch target.
- flush_ifid, out, 1, squash the IF/ID instruction.
- branch_cnt, out, 16, branches resolved.
- taken_cnt, out, 16, branches taken.
- stall_cnt, out, 16, branch stall cycles.

Function
REQ-002 SHALL drive comp_op = id_comp_op combinationally at all times.
REQ-003 SHALL treat rt as a used operand only for comp_op 0 and 1; rs SHALL always be a used operand.
REQ-004 SHALL never match register 0 as a hazard.
REQ-005 SHALL compute the stall need N, evaluated in the listed order:
- N=2 if a used operand equals ex_rd with ex_regwrite=1 and ex_memread=1.
- else N=1 if a used operand equals ex_rd with ex_regwrite=1.
- else N=1 if a used operand equals mem_rd with mem_regwrite=1 and mem_memread=1.
- else N=0.
REQ-006 SHALL implement the FSM states IDLE, WAIT and RESOLVE, with a 2-bit counter cnt.
REQ-007 IDLE, id_branch=1, N=0:
- resolve in the same cycle: pc_sel=flush_ifid=comp_true, stall=0.
- stay in IDLE.
REQ-008 IDLE, id_branch=1, N>0:
- stall=1, pc_sel=flush_ifid=0.
- load cnt=N-1, next state WAIT if N=2, else RESOLVE.
REQ-009 WAIT:
- stall=1, decrement cnt.
- next state RESOLVE when cnt reaches 0.
REQ-010 RESOLVE:
- stall=0, pc_sel=flush_ifid=comp_true.
- next state IDLE unconditionally; id_branch SHALL NOT re-trigger in this cycle.
REQ-011 IDLE with id_branch=0 SHALL drive stall=pc_sel=flush_ifid=0.
REQ-012 pipe_flush=1 SHALL have priority over everything else:
- force stall=pc_sel=flush_ifid=0 in that cycle.
- next state IDLE, cnt=0.
- no counter update.
REQ-013 The total branch latency SHALL be N+1 cycles from the first id_branch cycle to the resolution cycle.
REQ-014 In each resolution cycle, branch_cnt SHALL increment by 1, and taken_cnt SHALL increment by 1 if comp_true=1.
REQ-015 stall_cnt SHALL increment in every cycle with stall=1.
REQ-016 All counters SHALL saturate at 16'hFFFF and never wrap.
REQ-017 stats_clr=1 SHALL zero all three counters at the next edge and take priority over increments in that cycle.
REQ-018 The control outputs stall, pc_sel and flush_ifid SHALL be combinational from the state and inputs; the counters SHALL be registered.

Reset
REQ-019 While rst_n=0, the block SHALL asynchronously force:
- state to IDLE and cnt=0.
- branch_cnt=taken_cnt=stall_cnt=0.
REQ-020 Reset asserted mid-WAIT or mid-RESOLVE SHALL abandon the branch with no counter update; the first edge after release SHALL operate from IDLE.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- beq, rs=3, rt=4, no hazards, comp_true=1 -> same cycle stall=0, pc_sel=1, flush_ifid=1; branch_cnt=1, taken_cnt=1.
- bne, rt=5, EX load with ex_rd=5 -> stall=1 for 2 cycles, then RESOLVE with pc_sel=comp_true; stall_cnt=2.
- bgtz, rs=7, rt=9, EX ALU write with ex_rd=9 -> no stall (rt unused); bgtz, rs=7, MEM load with mem_rd=7 -> stall 1 cycle.
- beq, rs=0, EX load with ex_rd=0 -> no stall.
- pipe_flush=1 during WAIT -> outputs 0, next state IDLE, branch_cnt unchanged.
- Preload branch_cnt=16'hFFFF, resolve one branch -> stays 16'hFFFF; stats_clr=1 -> all counters 0.
